// File: rtl/eth_wb_cfg_pkg.sv
// Shared types and helpers for the Ethernet MAC Wishbone configuration master.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package eth_wb_cfg_pkg;

    localparam int WB_DW = 32;
    localparam int WB_SW = 4;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        GAP,
        RD,
        RESP
    } state_t;

    // One select bit per byte lane, widened to a full-word compare mask.
    function automatic logic [WB_DW-1:0] sel_to_mask(input logic [WB_SW-1:0] sel);
        logic [WB_DW-1:0] mask;
        mask = '0;
        for (int i = 0; i < WB_SW; i++) begin
            mask[8*i +: 8] = {8{sel[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/eth_wb_timeout.sv
// Wishbone cycle watchdog: counts stalled bus cycles and flags the abort point.
// Latency: expired is combinational from the count, asserted on the edge the count would reach LIMIT.
// Backpressure: none; clr wins over en.
// Ports: clk, rst (sync, active-high), clr (hold count at 0), en (stall cycle), expired (abort now).
module eth_wb_timeout #(
    parameter int LIMIT = 255,
    parameter int W     = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    // Fires on the stall edge that moves the count onto LIMIT, so the bus
    // is released after exactly LIMIT unterminated strobe cycles.
    assign expired = en && (count == W'(LIMIT - 1));

endmodule

// File: rtl/eth_wb_cfg_master.sv
// Wishbone classic master driving the MAC register port: one bus cycle per request, optional write-verify readback.
// Latency: bus cycle starts the cycle after accept; response the cycle after ack/err/timeout (+1 gap + readback when verifying).
// Backpressure: req_ready_o only in IDLE; response held stable in RESP until rsp_ready_i.
// Ports: req_* request handshake in, rsp_* response handshake out, wb_* Wishbone master signals; all outputs registered.
module eth_wb_cfg_master
    import eth_wb_cfg_pkg::*;
#(
    parameter int ADR_W          = 10,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_W           = 8
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic              req_verify_i,
    input  logic [ADR_W-1:0]  req_adr_i,
    input  logic [WB_DW-1:0]  req_dat_i,
    input  logic [WB_SW-1:0]  req_sel_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [WB_DW-1:0]  rsp_dat_o,
    output logic              rsp_err_o,
    output logic              rsp_timeout_o,
    output logic              rsp_mismatch_o,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic [ADR_W-1:0]  wb_adr_o,
    output logic [WB_SW-1:0]  wb_sel_o,
    output logic [WB_DW-1:0]  wb_dat_o,
    input  logic [WB_DW-1:0]  wb_dat_i,
    input  logic              wb_ack_i,
    input  logic              wb_err_i
);

    state_t state;
    logic   verify_q;   // write request asked for a readback
    logic   rdbk_q;     // current RD cycle is the verify readback
    logic   in_cycle;
    logic   tmo_expired;

    assign in_cycle = (state == WR) || (state == RD);

    // Held clear outside WR/RD, so every bus cycle starts counting from 0.
    eth_wb_timeout #(
        .LIMIT (TIMEOUT_CYCLES),
        .W     (TO_W)
    ) u_timeout (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .clr     (!in_cycle),
        .en      (in_cycle && !wb_ack_i && !wb_err_i),
        .expired (tmo_expired)
    );

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state          <= IDLE;
            verify_q       <= 1'b0;
            rdbk_q         <= 1'b0;
            req_ready_o    <= 1'b0;
            rsp_valid_o    <= 1'b0;
            rsp_dat_o      <= '0;
            rsp_err_o      <= 1'b0;
            rsp_timeout_o  <= 1'b0;
            rsp_mismatch_o <= 1'b0;
            wb_cyc_o       <= 1'b0;
            wb_stb_o       <= 1'b0;
            wb_we_o        <= 1'b0;
            wb_adr_o       <= '0;
            wb_sel_o       <= '0;
            wb_dat_o       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    req_ready_o <= 1'b1;
                    if (req_valid_i && req_ready_o) begin
                        req_ready_o <= 1'b0;
                        wb_adr_o    <= req_adr_i;
                        wb_sel_o    <= req_sel_i;
                        wb_dat_o    <= req_dat_i;
                        verify_q    <= req_we_i && req_verify_i;
                        rdbk_q      <= 1'b0;
                        wb_cyc_o    <= 1'b1;
                        wb_stb_o    <= 1'b1;
                        wb_we_o     <= req_we_i;
                        state       <= req_we_i ? WR : RD;
                    end
                end

                WR, RD: begin
                    if (wb_err_i || wb_ack_i || tmo_expired) begin
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        wb_we_o  <= 1'b0;
                    end
                    // err beats ack; an ack on the expiry edge still completes normally.
                    if (wb_err_i) begin
                        rsp_valid_o    <= 1'b1;
                        rsp_err_o      <= 1'b1;
                        rsp_timeout_o  <= 1'b0;
                        rsp_mismatch_o <= 1'b0;
                        rsp_dat_o      <= '0;
                        state          <= RESP;
                    end else if (wb_ack_i) begin
                        if (state == WR && verify_q) begin
                            state <= GAP;
                        end else begin
                            rsp_valid_o    <= 1'b1;
                            rsp_err_o      <= 1'b0;
                            rsp_timeout_o  <= 1'b0;
                            rsp_dat_o      <= (state == RD) ? wb_dat_i : '0;
                            rsp_mismatch_o <= (state == RD) && rdbk_q &&
                                              (|((wb_dat_i ^ wb_dat_o) & sel_to_mask(wb_sel_o)));
                            state          <= RESP;
                        end
                    end else if (tmo_expired) begin
                        rsp_valid_o    <= 1'b1;
                        rsp_err_o      <= 1'b1;
                        rsp_timeout_o  <= 1'b1;
                        rsp_mismatch_o <= 1'b0;
                        rsp_dat_o      <= '0;
                        state          <= RESP;
                    end
                end

                // Single idle bus cycle, then the readback at the same adr/sel.
                GAP: begin
                    wb_cyc_o <= 1'b1;
                    wb_stb_o <= 1'b1;
                    wb_we_o  <= 1'b0;
                    rdbk_q   <= 1'b1;
                    state    <= RD;
                end

                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o    <= 1'b0;
                        rsp_dat_o      <= '0;
                        rsp_err_o      <= 1'b0;
                        rsp_timeout_o  <= 1'b0;
                        rsp_mismatch_o <= 1'b0;
                        req_ready_o    <= 1'b1;
                        state          <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eth_wb_cfg_master.sv
// Self-checking bench for eth_wb_cfg_master: directed vector table, reset corner cases, randomized traffic vs. a transaction-level model.
// Latency: n/a.
// Backpressure: bench holds rsp_ready low for a per-transaction number of cycles.
module tb_eth_wb_cfg_master;

    localparam int ADR_W = 10;
    localparam int TMO   = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid, req_ready, req_we, req_verify;
    logic [ADR_W-1:0]  req_adr;
    logic [31:0]       req_dat;
    logic [3:0]        req_sel;
    logic              rsp_valid, rsp_ready, rsp_err, rsp_to, rsp_mm;
    logic [31:0]       rsp_dat;
    logic              wb_cyc, wb_stb, wb_we, wb_ack, wb_err;
    logic [ADR_W-1:0]  wb_adr;
    logic [3:0]        wb_sel;
    logic [31:0]       wb_dat_o, wb_dat_i;

    always #5 clk = ~clk;

    eth_wb_cfg_master #(
        .ADR_W          (ADR_W),
        .TIMEOUT_CYCLES (TMO),
        .TO_W           (8)
    ) dut (
        .wb_clk_i       (clk),
        .wb_rst_i       (rst),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_we_i       (req_we),
        .req_verify_i   (req_verify),
        .req_adr_i      (req_adr),
        .req_dat_i      (req_dat),
        .req_sel_i      (req_sel),
        .rsp_valid_o    (rsp_valid),
        .rsp_ready_i    (rsp_ready),
        .rsp_dat_o      (rsp_dat),
        .rsp_err_o      (rsp_err),
        .rsp_timeout_o  (rsp_to),
        .rsp_mismatch_o (rsp_mm),
        .wb_cyc_o       (wb_cyc),
        .wb_stb_o       (wb_stb),
        .wb_we_o        (wb_we),
        .wb_adr_o       (wb_adr),
        .wb_sel_o       (wb_sel),
        .wb_dat_o       (wb_dat_o),
        .wb_dat_i       (wb_dat_i),
        .wb_ack_i       (wb_ack),
        .wb_err_i       (wb_err)
    );

    typedef struct packed {
        logic        err;
        logic        to;
        logic        mm;
        logic [31:0] dat;
        logic [3:0]  ncyc;
        logic [3:0]  len1;
        logic [3:0]  len2;
    } exp_t;

    typedef struct {
        logic        we;
        logic        ver;
        logic [9:0]  adr;
        logic [31:0] wd;
        logic [3:0]  sel;
        int          a1;
        int          e1;
        logic [31:0] d1;
        int          a2;
        int          e2;
        logic [31:0] d2;
        int          hold;
        exp_t        x;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // Observations from the last transaction.
    logic        o_got, o_err, o_to, o_mm;
    logic [31:0] o_dat;
    int          o_ncyc, o_len1, o_len2, o_gap, o_proto_bad, o_bus_bad, o_stable_bad;
    logic        o_rdy_after;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic exp_t mk_exp(input logic err, input logic to, input logic mm,
                                    input logic [31:0] dat, input int ncyc, input int len1, input int len2);
        exp_t x;
        x.err = err; x.to = to; x.mm = mm; x.dat = dat;
        x.ncyc = 4'(ncyc); x.len1 = 4'(len1); x.len2 = 4'(len2);
        return x;
    endfunction

    // How a bus cycle ends given the slave's ack/err strobe index (0 = never):
    // kind 0 = ack, 1 = err, 2 = timeout; len = strobe cycles seen.
    task automatic bus_end(input int a, input int e, output int kind, output int len);
        if (e >= 1 && e <= TMO && (a == 0 || e <= a)) begin
            kind = 1; len = e;
        end else if (a >= 1 && a <= TMO) begin
            kind = 0; len = a;
        end else begin
            kind = 2; len = TMO;
        end
    endtask

    task automatic model(input vec_t v, output exp_t x);
        int k1, l1, k2, l2;
        x = '0;
        bus_end(v.a1, v.e1, k1, l1);
        x.ncyc = 4'd1;
        x.len1 = 4'(l1);
        if (k1 == 1) begin
            x.err = 1'b1;
        end else if (k1 == 2) begin
            x.err = 1'b1; x.to = 1'b1;
        end else if (!v.we) begin
            x.dat = v.d1;
        end else if (v.ver) begin
            bus_end(v.a2, v.e2, k2, l2);
            x.ncyc = 4'd2;
            x.len2 = 4'(l2);
            if (k2 == 1) begin
                x.err = 1'b1;
            end else if (k2 == 2) begin
                x.err = 1'b1; x.to = 1'b1;
            end else begin
                x.dat = v.d2;
                for (int b = 0; b < 4; b++)
                    if (v.sel[b] && (v.d2[8*b +: 8] != v.wd[8*b +: 8])) x.mm = 1'b1;
            end
        end
    endtask

    // Issue one request, play the slave, collect and release the response.
    task automatic run_txn(input vec_t v);
        int n, stbn, wbc, gap, a, e;
        logic [31:0] d;
        o_got = 1'b0; o_ncyc = 0; o_len1 = 0; o_len2 = 0; o_gap = 0;
        o_proto_bad = 0; o_bus_bad = 0; o_stable_bad = 0; o_rdy_after = 1'b0;
        req_we = v.we; req_verify = v.ver; req_adr = v.adr; req_dat = v.wd; req_sel = v.sel;
        req_valid = 1'b1;
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("req_accepted", 32'(n < 20), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        stbn = 0; wbc = 0; gap = 0;
        for (int c = 0; c < 60 && rsp_valid !== 1'b1; c++) begin
            if (req_ready !== 1'b0) o_proto_bad++;
            if (wb_cyc === 1'b1) begin
                if (stbn == 0) begin
                    wbc++;
                    if (wbc == 2) o_gap = gap;
                end
                stbn++;
                if (wbc == 1) o_len1 = stbn; else o_len2 = stbn;
                if (wb_stb !== 1'b1 || wb_we !== ((wbc == 1) ? v.we : 1'b0)) o_proto_bad++;
                if (wb_adr !== v.adr || wb_sel !== v.sel || (wb_we === 1'b1 && wb_dat_o !== v.wd)) o_bus_bad++;
                a = (wbc == 1) ? v.a1 : v.a2;
                e = (wbc == 1) ? v.e1 : v.e2;
                d = (wbc == 1) ? v.d1 : v.d2;
                wb_ack = (stbn == a);
                wb_err = (stbn == e);
                wb_dat_i = wb_ack ? d : $urandom();
            end else begin
                stbn = 0; wb_ack = 1'b0; wb_err = 1'b0;
                if (wb_we !== 1'b0 || wb_stb !== 1'b0) o_proto_bad++;
                if (wbc > 0) gap++;
            end
            @(negedge clk);
        end
        wb_ack = 1'b0; wb_err = 1'b0;
        o_ncyc = wbc;
        o_got = rsp_valid; o_err = rsp_err; o_to = rsp_to; o_mm = rsp_mm; o_dat = rsp_dat;
        if (req_ready !== 1'b0) o_stable_bad++;
        for (int k = 0; k < v.hold; k++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_err !== o_err || rsp_to !== o_to || rsp_mm !== o_mm ||
                rsp_dat !== o_dat || req_ready !== 1'b0 || wb_cyc !== 1'b0) o_stable_bad++;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        o_rdy_after = (rsp_valid === 1'b0) && (req_ready === 1'b1);
    endtask

    task automatic cmp(input string tag, input int idx, input exp_t x);
        string p;
        p = $sformatf("%s%0d", tag, idx);
        check({p, ".rsp_seen"}, 32'(o_got), 32'd1);
        check({p, ".err"}, 32'(o_err), 32'(x.err));
        check({p, ".timeout"}, 32'(o_to), 32'(x.to));
        check({p, ".mismatch"}, 32'(o_mm), 32'(x.mm));
        check({p, ".dat"}, o_dat, x.dat);
        check({p, ".bus_cycles"}, 32'(o_ncyc), 32'(x.ncyc));
        check({p, ".len1"}, 32'(o_len1), 32'(x.len1));
        if (x.ncyc == 4'd2) begin
            check({p, ".len2"}, 32'(o_len2), 32'(x.len2));
            check({p, ".gap"}, 32'(o_gap), 32'd1);
        end
        check({p, ".protocol"}, 32'(o_proto_bad), 32'd0);
        check({p, ".bus_fields"}, 32'(o_bus_bad), 32'd0);
        check({p, ".rsp_stable"}, 32'(o_stable_bad), 32'd0);
        check({p, ".ready_after"}, 32'(o_rdy_after), 32'd1);
    endtask

    vec_t vecs[12];

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t v;
        exp_t x;
        int bad;

        vecs[0]  = '{1'b1, 1'b0, 10'h000, 32'h12345678, 4'hF, 3, 0, 32'h0, 0, 0, 32'h0, 0,
                     mk_exp(1'b0, 1'b0, 1'b0, 32'h0, 1, 3, 0)};
        vecs[1]  = '{1'b0, 1'b0, 10'h001, 32'h0, 4'hF, 2, 0, 32'hA5A50000, 0, 0, 32'h0, 5,
                     mk_exp(1'b0, 1'b0, 1'b0, 32'hA5A50000, 1, 2, 0)};
        vecs[2]  = '{1'b1, 1'b1, 10'h002, 32'hDEADBEEF, 4'hF, 1, 0, 32'h0, 1, 0, 32'hDEADBEEF, 0,
                     mk_exp(1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 2, 1, 1)};
        vecs[3]  = '{1'b1, 1'b1, 10'h002, 32'hDEADBEEF, 4'hF, 2, 0, 32'h0, 2, 0, 32'hDEADBEEE, 1,
                     mk_exp(1'b0, 1'b0, 1'b1, 32'hDEADBEEE, 2, 2, 2)};
        vecs[4]  = '{1'b1, 1'b1, 10'h003, 32'h000000EF, 4'h1, 1, 0, 32'h0, 1, 0, 32'hFFFFFFEF, 0,
                     mk_exp(1'b0, 1'b0, 1'b0, 32'hFFFFFFEF, 2, 1, 1)};
        vecs[5]  = '{1'b0, 1'b0, 10'h004, 32'h0, 4'hF, 0, 0, 32'h0, 0, 0, 32'h0, 0,
                     mk_exp(1'b1, 1'b1, 1'b0, 32'h0, 1, 8, 0)};
        vecs[6]  = '{1'b0, 1'b0, 10'h004, 32'h0, 4'hF, 8, 0, 32'h0BADF00D, 0, 0, 32'h0, 0,
                     mk_exp(1'b0, 1'b0, 1'b0, 32'h0BADF00D, 1, 8, 0)};
        vecs[7]  = '{1'b1, 1'b1, 10'h005, 32'h55AA55AA, 4'hF, 1, 1, 32'h0, 1, 0, 32'h0, 0,
                     mk_exp(1'b1, 1'b0, 1'b0, 32'h0, 1, 1, 0)};
        vecs[8]  = '{1'b1, 1'b1, 10'h006, 32'h01020304, 4'hF, 1, 0, 32'h0, 3, 3, 32'h01020304, 0,
                     mk_exp(1'b1, 1'b0, 1'b0, 32'h0, 2, 1, 3)};
        vecs[9]  = '{1'b1, 1'b1, 10'h3FF, 32'hCAFEF00D, 4'hF, 2, 0, 32'h0, 0, 0, 32'h0, 2,
                     mk_exp(1'b1, 1'b1, 1'b0, 32'h0, 2, 2, 8)};
        vecs[10] = '{1'b1, 1'b0, 10'h007, 32'h13579BDF, 4'h3, 0, 0, 32'h0, 0, 0, 32'h0, 0,
                     mk_exp(1'b1, 1'b1, 1'b0, 32'h0, 1, 8, 0)};
        vecs[11] = '{1'b1, 1'b1, 10'h008, 32'h11223344, 4'h6, 1, 0, 32'h0, 2, 0, 32'hFF2233FF, 0,
                     mk_exp(1'b0, 1'b0, 1'b0, 32'hFF2233FF, 2, 1, 2)};

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_verify = 1'b0;
        req_adr = '0; req_dat = '0; req_sel = '0; rsp_ready = 1'b0;
        wb_ack = 1'b0; wb_err = 1'b0; wb_dat_i = '0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst.req_ready", 32'(req_ready), 32'd0);
        check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst.wb_ctl", 32'({wb_cyc, wb_stb, wb_we}), 32'd0);
        check("rst.wb_adr_sel", 32'({wb_adr, wb_sel}), 32'd0);
        check("rst.wb_dat", wb_dat_o, 32'd0);
        check("rst.rsp_dat", rsp_dat, 32'd0);
        check("rst.rsp_flags", 32'({rsp_err, rsp_to, rsp_mm}), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst.ready_after_release", 32'(req_ready), 32'd1);

        // Directed vectors
        for (int i = 0; i < 12; i++) begin
            run_txn(vecs[i]);
            cmp("vec", i, vecs[i].x);
        end

        // Reset during a read bus cycle
        req_we = 1'b0; req_verify = 1'b0; req_adr = 10'h010; req_sel = 4'hF; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        check("midrst.cyc_before", 32'({wb_cyc, wb_stb, wb_we}), 32'b110);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst.wb_ctl", 32'({wb_cyc, wb_stb, wb_we}), 32'd0);
        check("midrst.rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst.req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        check("midrst.ready_after_release", 32'(req_ready), 32'd1);
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            wb_ack = 1'b1;  // stray ack must not revive the aborted read
            if (rsp_valid !== 1'b0 || wb_cyc !== 1'b0) bad++;
            @(negedge clk);
        end
        wb_ack = 1'b0;
        check("midrst.no_response", 32'(bad), 32'd0);
        v = '{1'b0, 1'b0, 10'h011, 32'h0, 4'hF, 1, 0, 32'h600DF00D, 0, 0, 32'h0, 0,
              mk_exp(1'b0, 1'b0, 1'b0, 32'h600DF00D, 1, 1, 0)};
        run_txn(v);
        cmp("midrst.after", 0, v.x);

        // Randomized traffic against the transaction model
        for (int i = 0; i < 40; i++) begin
            v.we   = 1'($urandom_range(0, 1));
            v.ver  = 1'($urandom_range(0, 1));
            v.adr  = 10'($urandom);
            v.wd   = $urandom();
            v.sel  = 4'($urandom_range(0, 15));
            v.a1   = $urandom_range(0, 10);
            v.e1   = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 9) : 0;
            v.d1   = $urandom();
            v.a2   = $urandom_range(0, 10);
            v.e2   = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 9) : 0;
            v.d2   = ($urandom_range(0, 1) == 1) ? (v.wd ^ (32'hFF << (8 * $urandom_range(0, 3)))) : v.wd;
            v.hold = $urandom_range(0, 3);
            model(v, x);
            run_txn(v);
            cmp("rnd", i, x);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
